noc_packet_injector: RTL and testbench
======================================

NOC_PACKET_INJECTOR -- requirements
Module: noc_packet_injector

Interface
REQ-001 Parameter: SRC_ID, default 0, 2-bit node id of the attached processor, placed in every flit.
REQ-002 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  reset is asynchronous and active-low (reset=0 clears all state immediately).
REQ-004 Port: configure  input  11  processor config word; [0] go, [2:1] destination node, [6:3] body-flit count N (0-15), [10:7] payload seed S.
REQ-005 Port: flit_out  output  16  flit to router local port; [15:14] type (01 head, 00 body, 10 tail), [13:12] SRC_ID, [11:10] dst, [9:0] payload.
REQ-006 Port: flit_valid  output  1  flit_out holds a valid flit.
REQ-007 Port: flit_ready  input  1  router accepts flit_out this cycle.
REQ-008 Port: processor_ready  output  1  current request finished; held until go drops.
REQ-009 Port: cfg_error  output  1  last request rejected (dst == SRC_ID).
REQ-010 Port: pkt_count  output  8  count of packets fully transmitted since reset.

Function
REQ-011 FSM states SHALL be IDLE, HEAD, BODY, TAIL, DONE.
REQ-012 In IDLE, configure[0]=1 at a rising edge SHALL latch configure; next state HEAD (dst != SRC_ID) or DONE with cfg_error=1 (dst == SRC_ID, no flits sent).
REQ-013 configure changes after latching SHALL be ignored until the FSM returns to IDLE.
REQ-014 flit_valid SHALL be 1 exactly in HEAD, BODY, TAIL; a flit transfers on a rising edge with flit_valid=1 and flit_ready=1.
REQ-015 While flit_valid=1 and flit_ready=0, flit_out SHALL remain stable and the state SHALL not change.
REQ-016 Head payload SHALL be {S, 2'b00, N}; after transfer go to BODY if N>0, else TAIL.
REQ-017 Body flit k (k=0..N-1) payload SHALL be {S, k[5:0]}; after flit N-1 transfers go to TAIL.
REQ-018 Tail payload SHALL be the sum of all body payloads modulo 1024 (0 when N=0).
REQ-019 Tail transfer SHALL move to DONE and increment pkt_count by 1, wrapping 255->0.
REQ-020 processor_ready SHALL be 1 exactly in DONE; DONE with configure[0]=0 at an edge returns to IDLE; while go stays 1 the block remains in DONE (no re-send).
REQ-021 cfg_error SHALL be cleared when a new request is latched in IDLE and set only per REQ-012.
REQ-022 Latency: first flit_valid=1 one cycle after go is sampled in IDLE; processor_ready=1 one cycle after tail transfer.
REQ-023 flit_out SHALL be 0 whenever flit_valid=0.

Reset
REQ-024 reset=0 SHALL immediately force IDLE, flit_valid=0, flit_out=0, processor_ready=0, cfg_error=0, pkt_count=0, clear latched config and checksum, regardless of clock.
REQ-025 Reset asserted mid-packet SHALL abandon the packet with no further flits; after release, go=1 starts a fresh packet from HEAD.

Verification
REQ-026 SRC_ID=0, configure=11'b00001000011, flit_ready=1 -> flits 0x4408, body 0x0400..0x0407, tail 0x841C; 10 flits consecutive; processor_ready=1 next cycle; pkt_count=1.
REQ-027 configure=11'b00000000011 -> head 0x4400, tail 0x8400, no body flits; pkt_count increments.
REQ-028 Same as REQ-026 with flit_ready toggled 1,0,0,1,... -> identical flit sequence, each flit held stable through stalls, no duplicates or drops.
REQ-029 SRC_ID=0, configure=11'b00000000001 -> no flit_valid, cfg_error=1 and processor_ready=1 one cycle later; go=0 -> IDLE, processor_ready=0.
REQ-030 reset=0 pulsed asynchronously during body flit 3 -> flit_valid drops in same cycle, all outputs 0; after release a new request produces a complete correct packet.
REQ-031 256 back-to-back packets (go toggled per packet) -> pkt_count wraps to 0; go held 1 in DONE -> no second packet.

Source files
------------

// File: rtl/noc_packet_injector_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | noc_packet_injector_if : processor config + router local-port bus  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface noc_packet_injector_if;
  logic [10:0] configure;
  logic [15:0] flit_out;
  logic        flit_valid;
  logic        flit_ready;
  logic        processor_ready;
  logic        cfg_error;
  logic [7:0]  pkt_count;

  modport master (
    input  configure,
    input  flit_ready,
    output flit_out,
    output flit_valid,
    output processor_ready,
    output cfg_error,
    output pkt_count
  );

  modport slave (
    output configure,
    output flit_ready,
    input  flit_out,
    input  flit_valid,
    input  processor_ready,
    input  cfg_error,
    input  pkt_count
  );
endinterface
`default_nettype wire

// File: rtl/noc_packet_injector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | noc_packet_injector : turns a processor config word into a        |
// | head/body/tail flit packet on the router local port.               |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module noc_packet_injector #(
  parameter logic [1:0] SRC_ID = 2'd0
) (
  input  wire logic              clock,
  input  wire logic              reset,
  noc_packet_injector_if.master  bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HEAD = 3'd1;
  localparam logic [2:0] ST_BODY = 3'd2;
  localparam logic [2:0] ST_TAIL = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_BODY = 2'b00;
  localparam logic [1:0] TYPE_TAIL = 2'b10;

  logic [2:0] state;
  logic [1:0] dst;
  logic [3:0] body_n;
  logic [3:0] seed;
  logic [3:0] body_idx;
  logic [9:0] checksum;
  logic       cfg_error;
  logic [7:0] pkt_count;

  logic       go;
  logic [1:0] cfg_dst;
  logic [9:0] body_payload;
  logic       valid;

  assign go           = bus.configure[0];
  assign cfg_dst      = bus.configure[2:1];
  assign body_payload = {seed, 2'b00, body_idx};
  assign valid        = (state == ST_HEAD) || (state == ST_BODY) || (state == ST_TAIL);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      dst       <= 2'd0;
      body_n    <= 4'd0;
      seed      <= 4'd0;
      body_idx  <= 4'd0;
      checksum  <= 10'd0;
      cfg_error <= 1'b0;
      pkt_count <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            dst       <= cfg_dst;
            body_n    <= bus.configure[6:3];
            seed      <= bus.configure[10:7];
            body_idx  <= 4'd0;
            checksum  <= 10'd0;
            // A packet addressed to ourselves is refused without emitting flits
            cfg_error <= (cfg_dst == SRC_ID);
            state     <= (cfg_dst == SRC_ID) ? ST_DONE : ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (bus.flit_ready) begin
            state <= (body_n != 4'd0) ? ST_BODY : ST_TAIL;
          end
        end
        ST_BODY: begin
          if (bus.flit_ready) begin
            checksum <= checksum + body_payload;
            body_idx <= body_idx + 4'd1;
            if (body_idx == body_n - 4'd1) begin
              state <= ST_TAIL;
            end
          end
        end
        ST_TAIL: begin
          if (bus.flit_ready) begin
            pkt_count <= pkt_count + 8'd1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!go) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Flit is decoded from registered state so it stays stable across stalls
  always_comb begin
    bus.flit_out = 16'd0;
    case (state)
      ST_HEAD: bus.flit_out = {TYPE_HEAD, SRC_ID, dst, seed, 2'b00, body_n};
      ST_BODY: bus.flit_out = {TYPE_BODY, SRC_ID, dst, body_payload};
      ST_TAIL: bus.flit_out = {TYPE_TAIL, SRC_ID, dst, checksum};
      default: bus.flit_out = 16'd0;
    endcase
  end

  assign bus.flit_valid      = valid;
  assign bus.processor_ready = (state == ST_DONE);
  assign bus.cfg_error       = cfg_error;
  assign bus.pkt_count       = pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_noc_packet_injector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_noc_packet_injector : randomized self-checking bench against a  |
// | packet-level reference model.  Revision: 1.0                       |
// +--------------------------------------------------------------------+
module tb_noc_packet_injector;

  logic       clock;
  logic       reset;
  int         n_checks;
  int         n_errors;
  logic [7:0] exp_cnt;

  noc_packet_injector_if bus();

  noc_packet_injector #(.SRC_ID(2'd0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // stall_mode: 0 always ready, 1 ready pattern 1,0,0, 2 random ready
  task automatic run_packet(input logic [10:0] cfg, input int stall_mode, input bit scramble);
    logic [15:0] exp_q[$];
    logic [1:0]  d;
    logic [3:0]  s;
    logic [3:0]  n;
    logic [9:0]  p;
    logic [9:0]  tail_sum;
    int          sum;
    int          idx;
    int          cyc;
    int          ph;
    bit          err;
    bit          rdy;
    logic [10:0] junk;

    d   = cfg[2:1];
    n   = cfg[6:3];
    s   = cfg[10:7];
    err = (d == 2'd0);
    if (!err) begin
      exp_q.push_back({2'b01, 2'b00, d, s, 2'b00, n});
      sum = 0;
      for (int k = 0; k < int'(n); k++) begin
        p = 10'(int'(s) * 64 + k);
        exp_q.push_back({2'b00, 2'b00, d, p});
        sum += int'(p);
      end
      tail_sum = 10'(sum % 1024);
      exp_q.push_back({2'b10, 2'b00, d, tail_sum});
    end

    @(negedge clock);
    bus.configure  = cfg;
    bus.flit_ready = 1'b0;
    @(negedge clock);
    check("first_valid", {31'd0, bus.flit_valid}, {31'd0, !err});
    if (err) begin
      check("err_ready", {31'd0, bus.processor_ready}, 32'd1);
    end else begin
      check("err_cleared", {31'd0, bus.cfg_error}, 32'd0);
    end

    idx = 0;
    cyc = 0;
    ph  = 0;
    while (idx < exp_q.size() && cyc < 200) begin
      check("valid", {31'd0, bus.flit_valid}, 32'd1);
      check("flit", {16'd0, bus.flit_out}, {16'd0, exp_q[idx]});
      case (stall_mode)
        0:       rdy = 1'b1;
        1:       rdy = (ph % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ph++;
      bus.flit_ready = rdy;
      if (scramble) begin
        junk = 11'($urandom);
        bus.configure = {junk[10:1], 1'b1};
      end
      if (rdy) idx++;
      @(negedge clock);
      cyc++;
    end
    if (cyc >= 200) check("timeout", 32'd1, 32'd0);

    if (!err) exp_cnt = exp_cnt + 8'd1;
    check("done_ready", {31'd0, bus.processor_ready}, 32'd1);
    check("done_valid", {31'd0, bus.flit_valid}, 32'd0);
    check("done_flit_zero", {16'd0, bus.flit_out}, 32'd0);
    check("pkt_count", {24'd0, bus.pkt_count}, {24'd0, exp_cnt});
    check("cfg_error", {31'd0, bus.cfg_error}, {31'd0, err});

    bus.configure  = cfg;
    bus.flit_ready = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("hold_ready", {31'd0, bus.processor_ready}, 32'd1);
      check("hold_no_resend", {31'd0, bus.flit_valid}, 32'd0);
    end
    check("hold_count", {24'd0, bus.pkt_count}, {24'd0, exp_cnt});

    bus.configure = 11'd0;
    @(negedge clock);
    check("idle_ready", {31'd0, bus.processor_ready}, 32'd0);
    check("idle_valid", {31'd0, bus.flit_valid}, 32'd0);
  endtask

  initial begin
    logic [10:0] rcfg;
    n_checks       = 0;
    n_errors       = 0;
    exp_cnt        = 8'd0;
    reset          = 1'b0;
    bus.configure  = 11'd0;
    bus.flit_ready = 1'b0;

    #1;
    check("rst_valid", {31'd0, bus.flit_valid}, 32'd0);
    check("rst_flit", {16'd0, bus.flit_out}, 32'd0);
    check("rst_count", {24'd0, bus.pkt_count}, 32'd0);
    check("rst_ready", {31'd0, bus.processor_ready}, 32'd0);
    check("rst_err", {31'd0, bus.cfg_error}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    run_packet(11'b00001000011, 0, 1'b0);
    run_packet(11'b00000000011, 0, 1'b0);
    run_packet(11'b00001000011, 1, 1'b0);
    run_packet(11'b00000000001, 0, 1'b0);
    run_packet(11'b11111111101, 1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      rcfg = {11'($urandom) | 11'd1};
      run_packet(rcfg, 2, ($urandom_range(0, 1) == 1));
    end

    // Asynchronous reset while body flit 3 is on the port
    @(negedge clock);
    bus.configure  = 11'b00001000011;
    bus.flit_ready = 1'b1;
    repeat (5) @(negedge clock);
    check("pre_reset_flit", {16'd0, bus.flit_out}, 32'h0403);
    #2;
    reset = 1'b0;
    #1;
    check("async_valid", {31'd0, bus.flit_valid}, 32'd0);
    check("async_flit", {16'd0, bus.flit_out}, 32'd0);
    check("async_count", {24'd0, bus.pkt_count}, 32'd0);
    check("async_ready", {31'd0, bus.processor_ready}, 32'd0);
    check("async_err", {31'd0, bus.cfg_error}, 32'd0);
    bus.configure = 11'd0;
    exp_cnt       = 8'd0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_reset_valid", {31'd0, bus.flit_valid}, 32'd0);
    run_packet(11'b00001000011, 0, 1'b0);

    // Drive the packet counter around to zero
    for (int i = 0; i < 255; i++) begin
      run_packet(11'b00000000011, 0, 1'b0);
    end
    check("wrap_zero", {24'd0, bus.pkt_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
